buzzer_seq: RTL and testbench

Parametrised multi-tone buzzer driver for the board speaker pin. It holds a writable table of `NUM_TONES` half-period divisors and generates a square wave from one entry at a time. Four modes are supported: fixed tone, timed sequence through the table, gated beep, and mute. It sits between the front-panel controls or a CPU write port and the `sp` output pin.

---
 rtl/buzzer_seq.sv | 154 +++++++++++++++
 tb/tb_buzzer_seq.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/buzzer_seq.sv
// Multi-tone buzzer driver: a writable table of half-period divisors feeds a
// square-wave generator, with fixed-tone, timed-sequence, gated-beep and mute
// modes. The speaker pin, step index and step pulse are all registered.
module buzzer_seq #(
  parameter int unsigned NUM_TONES   = 4,
  parameter int unsigned IDX_W       = 2,
  parameter int unsigned DIV_W       = 24,
  parameter int unsigned DEFAULT_DIV = 28409,
  parameter int unsigned STEP_TICKS  = 25000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             onoff,
  input  logic [1:0]       mode,
  input  logic [IDX_W-1:0] tone_sel,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [DIV_W-1:0] wr_data,
  output logic             sp,
  output logic [IDX_W-1:0] step,
  output logic             step_pulse
);

  localparam int unsigned      DCNT_W   = $clog2(STEP_TICKS);
  localparam logic [DCNT_W-1:0] DCNT_MAX = DCNT_W'(STEP_TICKS - 1);
  localparam logic [DIV_W-1:0]  DIV_RST  = DIV_W'(DEFAULT_DIV);
  localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(NUM_TONES - 1);

  typedef enum logic [1:0] {
    ModeFixed = 2'd0,
    ModeSeq   = 2'd1,
    ModeBeep  = 2'd2,
    ModeMute  = 2'd3
  } mode_e;

  // Divisor table and generator state
  logic [DIV_W-1:0]  tbl_q [NUM_TONES];
  logic [DIV_W-1:0]  cur_div_q, cur_div_d;
  logic [DIV_W-1:0]  hcnt_q, hcnt_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic              gate_q, gate_d;
  logic [IDX_W-1:0]  step_q, step_d;
  logic              sp_q, sp_d;
  logic              pulse_q, pulse_d;

  // Previous-cycle copies of the controls, for change/edge detection
  mode_e             mode_q;
  logic [IDX_W-1:0]  tone_q;
  logic              onoff_q;

  mode_e             mode_cur;
  logic              mode_chg, tone_chg, onoff_rise;
  logic              active, dwell_on, step_evt;
  logic              hard_rst, restart, rest;
  logic [IDX_W-1:0]  step_inc;

  assign mode_cur = mode_e'(mode);
  assign step_inc = (step_q == IDX_MAX) ? '0 : step_q + IDX_W'(1);

  // Restart detection and next-state for step, dwell, gate and generator
  always_comb begin
    mode_chg   = (mode_cur != mode_q);
    tone_chg   = ((mode_cur == ModeFixed) || (mode_cur == ModeBeep)) && (tone_sel != tone_q);
    onoff_rise = onoff && !onoff_q;
    active     = onoff && (mode_cur != ModeMute);
    dwell_on   = active && ((mode_cur == ModeSeq) || (mode_cur == ModeBeep));
    step_evt   = dwell_on && (dcnt_q == DCNT_MAX);
    // Restarts other than a step event also re-phase the dwell counter and gate
    hard_rst   = mode_chg || tone_chg || onoff_rise;
    restart    = hard_rst || step_evt;
    rest       = (cur_div_q == '0) || ((mode_cur == ModeBeep) && !gate_q);

    step_d = step_q;
    if (onoff) begin
      unique case (mode_cur)
        ModeFixed, ModeBeep: step_d = tone_sel;
        ModeSeq: begin
          if (mode_chg || onoff_rise) begin
            step_d = '0;
          end else if (step_evt) begin
            step_d = step_inc;
          end
        end
        ModeMute: step_d = step_q;
      endcase
    end

    // A simultaneous mode change / tone change swallows the step event
    pulse_d = step_evt && !hard_rst;

    dcnt_d = '0;
    gate_d = 1'b1;
    if (active && !hard_rst) begin
      dcnt_d = (dcnt_q == DCNT_MAX) ? '0 : dcnt_q + DCNT_W'(1);
      gate_d = step_evt ? !gate_q : gate_q;
    end

    sp_d      = 1'b0;
    hcnt_d    = '0;
    cur_div_d = tbl_q[step_q];
    if (!active || restart) begin
      // Reads the table before this cycle's write, so a same-cycle write is missed
      cur_div_d = tbl_q[step_d];
    end else if (rest) begin
      cur_div_d = tbl_q[step_q];
    end else if (hcnt_q == cur_div_q - DIV_W'(1)) begin
      sp_d      = !sp_q;
      cur_div_d = tbl_q[step_q];
    end else begin
      sp_d      = sp_q;
      hcnt_d    = hcnt_q + DIV_W'(1);
      cur_div_d = cur_div_q;
    end
  end

  // State registers and table write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_TONES); i++) begin
        tbl_q[i] <= DIV_RST;
      end
      cur_div_q <= DIV_RST;
      hcnt_q    <= '0;
      dcnt_q    <= '0;
      gate_q    <= 1'b1;
      step_q    <= '0;
      sp_q      <= 1'b0;
      pulse_q   <= 1'b0;
      mode_q    <= ModeFixed;
      tone_q    <= '0;
      // Treat onoff as already high so an enabled start-up is not a restart
      onoff_q   <= 1'b1;
    end else begin
      if (wr_en) begin
        tbl_q[wr_addr] <= wr_data;
      end
      cur_div_q <= cur_div_d;
      hcnt_q    <= hcnt_d;
      dcnt_q    <= dcnt_d;
      gate_q    <= gate_d;
      step_q    <= step_d;
      sp_q      <= sp_d;
      pulse_q   <= pulse_d;
      mode_q    <= mode_cur;
      tone_q    <= tone_sel;
      onoff_q   <= onoff;
    end
  end

  assign sp         = sp_q;
  assign step       = step_q;
  assign step_pulse = pulse_q;

endmodule

// File: tb/tb_buzzer_seq.sv
// Scoreboard bench for buzzer_seq: stimulus pushes expected output events
// (sp edges and step pulses, with cycle stamps); a monitor pops and compares.
module tb_buzzer_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        onoff;
  logic [1:0]  mode;
  logic [1:0]  tone_sel;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [23:0] wr_data;
  logic        sp;
  logic [1:0]  step;
  logic        step_pulse;

  buzzer_seq #(
    .NUM_TONES  (4),
    .IDX_W      (2),
    .DIV_W      (24),
    .DEFAULT_DIV(4),
    .STEP_TICKS (20)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .onoff     (onoff),
    .mode      (mode),
    .tone_sel  (tone_sel),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .sp        (sp),
    .step      (step),
    .step_pulse(step_pulse)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic       sp;
    logic [1:0] step;
    logic       pulse;
  } ev_t;

  ev_t  exp_q[$];
  int   errors = 0;
  int   checks = 0;
  logic mon_en = 1'b0;

  // Monitor: any cycle with an sp edge or a step pulse is an output event
  initial begin : monitor
    logic sp_prev;
    ev_t  e;
    sp_prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && ((sp !== sp_prev) || (step_pulse === 1'b1))) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got cyc=%0d sp=%0b step=%0d pulse=%0b, expected none",
                   cyc, sp, step, step_pulse);
        end else begin
          e = exp_q.pop_front();
          if ((e.cyc != cyc) || (e.sp !== sp) || (e.step !== step) || (e.pulse !== step_pulse)) begin
            errors++;
            $display("FAIL event: got cyc=%0d sp=%0b step=%0d pulse=%0b, expected cyc=%0d sp=%0b step=%0d pulse=%0b",
                     cyc, sp, step, step_pulse, e.cyc, e.sp, e.step, e.pulse);
          end
        end
      end
      sp_prev = sp;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_ev(input int c, input logic s, input int st, input logic p);
    ev_t e;
    e.cyc   = c;
    e.sp    = s;
    e.step  = st[1:0];
    e.pulse = p;
    exp_q.push_back(e);
  endtask

  // Toggles of a tone of half-period d that starts silent at cycle s
  task automatic push_phase(input int s, input int d, input int st, input int len);
    for (int k = 1; d * k < len; k++) begin
      push_ev(s + d * k, (k % 2) == 1, st, 1'b0);
    end
  endtask

  task automatic goto(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic open_win();
    mon_en = 1'b1;
  endtask

  task automatic close_win(input string name);
    ev_t e;
    mon_en = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s missing_event: got nothing, expected cyc=%0d sp=%0b step=%0d pulse=%0b",
               name, e.cyc, e.sp, e.step, e.pulse);
    end
  endtask

  task automatic wr(input int a, input int d);
    wr_en   = 1'b1;
    wr_addr = a[1:0];
    wr_data = d[23:0];
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  initial begin : stim
    int c;
    int r;
    rst_n    = 1'b0;
    onoff    = 1'b1;
    mode     = 2'd0;
    tone_sel = 2'd0;
    wr_en    = 1'b0;
    wr_addr  = 2'd0;
    wr_data  = 24'd0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_sp", sp, 0);
    chk("rst_step", step, 0);
    chk("rst_pulse", step_pulse, 0);

    // 1: fixed tone from reset, default half-period 4
    rst_n = 1'b1;
    c = cyc;
    open_win();
    for (int k = 1; k <= 6; k++) push_ev(c + 4 * k, (k % 2) == 1, 0, 1'b0);
    goto(c + 26);
    chk("s1_step", step, 0);
    close_win("s1");

    // 2: sequence through {2,3,4,5}
    wr(0, 2); wr(1, 3); wr(2, 4); wr(3, 5);
    mode = 2'd1;
    r = cyc + 1;
    goto(r);
    open_win();
    push_phase(r, 2, 0, 20);      push_ev(r + 20, 1'b0, 1, 1'b1);
    push_phase(r + 20, 3, 1, 20); push_ev(r + 40, 1'b0, 2, 1'b1);
    push_phase(r + 40, 4, 2, 20); push_ev(r + 60, 1'b0, 3, 1'b1);
    push_phase(r + 60, 5, 3, 20); push_ev(r + 80, 1'b0, 0, 1'b1);
    goto(r + 81);
    close_win("s2");

    // 3: beep on entry 1 (div 3), then entry 1 becomes a rest
    mode     = 2'd2;
    tone_sel = 2'd1;
    r = cyc + 1;
    goto(r);
    open_win();
    push_phase(r, 3, 1, 20);      push_ev(r + 20, 1'b0, 1, 1'b1);
    push_ev(r + 40, 1'b0, 1, 1'b1);
    push_phase(r + 40, 3, 1, 20); push_ev(r + 60, 1'b0, 1, 1'b1);
    goto(r + 61);
    wr(1, 0);
    push_ev(r + 80, 1'b0, 1, 1'b1);
    push_ev(r + 100, 1'b0, 1, 1'b1);
    goto(r + 101);
    close_win("s3");

    // 4: write to the playing entry mid half-period
    wr(0, 4);
    mode     = 2'd0;
    tone_sel = 2'd0;
    r = cyc + 1;
    goto(r);
    open_win();
    push_ev(r + 4, 1'b1, 0, 1'b0);
    goto(r + 1);
    wr(0, 7);
    push_ev(r + 11, 1'b0, 0, 1'b0);
    push_ev(r + 18, 1'b1, 0, 1'b0);
    push_ev(r + 25, 1'b0, 0, 1'b0);
    goto(r + 26);
    close_win("s4");

    // 5: onoff drop at step 2, re-enable, then mute
    wr(0, 2); wr(1, 3);
    mode = 2'd1;
    r = cyc + 1;
    goto(r);
    open_win();
    push_phase(r, 2, 0, 20);      push_ev(r + 20, 1'b0, 1, 1'b1);
    push_phase(r + 20, 3, 1, 20); push_ev(r + 40, 1'b0, 2, 1'b1);
    push_ev(r + 44, 1'b1, 2, 1'b0);
    push_ev(r + 46, 1'b0, 2, 1'b0);
    goto(r + 45);
    onoff = 1'b0;
    goto(r + 47);
    chk("s5_off_sp", sp, 0);
    chk("s5_off_step", step, 2);
    goto(r + 50);
    onoff = 1'b1;
    push_ev(r + 53, 1'b1, 0, 1'b0);
    push_ev(r + 55, 1'b0, 0, 1'b0);
    goto(r + 54);
    mode = 2'd3;
    goto(r + 80);
    chk("s5_mute_sp", sp, 0);
    close_win("s5");

    // 6: asynchronous reset while a tone plays
    mode     = 2'd0;
    tone_sel = 2'd3;
    r = cyc + 1;
    goto(r + 6);
    chk("s6_pre_sp", sp, 1);
    chk("s6_pre_step", step, 3);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s6_async_sp", sp, 0);
    chk("s6_async_step", step, 0);
    chk("s6_async_pulse", step_pulse, 0);
    @(negedge clk);
    tone_sel = 2'd0;
    @(negedge clk);
    rst_n = 1'b1;
    c = cyc;
    open_win();
    push_ev(c + 4, 1'b1, 0, 1'b0);
    push_ev(c + 8, 1'b0, 0, 1'b0);
    goto(c + 9);
    close_win("s6_tbl0");
    for (int sel = 1; sel < 4; sel++) begin
      tone_sel = sel[1:0];
      r = cyc + 1;
      goto(r);
      open_win();
      push_ev(r + 4, 1'b1, sel, 1'b0);
      push_ev(r + 8, 1'b0, sel, 1'b0);
      goto(r + 9);
      close_win("s6_tbl");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
